id_pipe: RTL and testbench
==========================

// Module: id_pipe
// PURPOSE
//  Parametrised decode stage with built-in ID/EX pipeline register. Decodes logic-immediate, LUI, LW and
//  SPECIAL AND/OR/XOR/NOR; reads the regfile, forwards from EX/MEM, detects load-use hazards, inserts bubbles
//  and honours downstream stall/flush. Sits between if_id and ex; outputs are registered and feed ex directly.
// PARAMETERS
//  DATA_W      32  datapath/register width; immediates zero/sign-extend to DATA_W
//  REG_ADDR_W   5  register address width; register 0 reads as zero, never forwarded
//  ADDR_W      32  PC width
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           synchronous reset, active-high
//  pc_i           in   ADDR_W      PC of inst_i
//  inst_i         in   32          instruction from if_id
//  id_valid_i     in   1           inst_i holds a real instruction
//  reg1_data_i    in   DATA_W      regfile read port 1 data
//  reg2_data_i    in   DATA_W      regfile read port 2 data
//  reg1_read_o    out  1           port 1 read enable (comb)
//  reg2_read_o    out  1           port 2 read enable (comb)
//  reg1_addr_o    out  REG_ADDR_W  inst_i[25:21] (comb)
//  reg2_addr_o    out  REG_ADDR_W  inst_i[20:16] (comb)
//  ex_wreg_i/ex_wd_i/ex_wdata_i    in 1/REG_ADDR_W/DATA_W  EX-stage write-back forward
//  mem_wreg_i/mem_wd_i/mem_wdata_i in 1/REG_ADDR_W/DATA_W  MEM-stage write-back forward
//  stall_i        in   1           downstream stall: hold ID/EX register
//  flush_i        in   1           clear ID/EX register to bubble
//  stallreq_o     out  1           load-use stall request to upstream (comb)
//  ex_valid_o     out  1           ID/EX entry valid
//  ex_pc_o        out  ADDR_W      registered PC
//  ex_aluop_o     out  8           defines.v EXE_*_OP code
//  ex_alusel_o    out  3           defines.v EXE_RES_* code
//  ex_reg1_o/ex_reg2_o  out DATA_W operands (forwarded reg or immediate)
//  ex_wd_o        out  REG_ADDR_W  destination register
//  ex_wreg_o      out  1           write enable
//  ex_is_load_o   out  1           entry is LW
//  invalid_inst_o out  1           one-cycle pulse: undecodable valid instruction
// BEHAVIOUR
//  Reset (rst=1 at clk edge): all ex_* = 0 (aluop EXE_NOP_OP, alusel EXE_RES_NOP), invalid_inst_o=0.
//  Decode (comb): ORI/ANDI/XORI zero-extend imm; LUI {imm,16'b0}, reg1 not read; LW: aluop add, operand2
//  sign-extended imm, wd=rt, is_load=1; SPECIAL funct 100100/100101/100110/100111 = AND/OR/XOR/NOR, wd=rd.
//  Immediate forms: wd=rt, reg2 not read, ex_reg2_o=imm. Unread operand = imm (reg2) or 0 (reg1).
//  All-zero inst = valid NOP, wreg=0. Any other opcode/funct = invalid: bubble + invalid_inst_o next cycle.
//  Forwarding per operand, priority: addr 0 -> 0; ex_wreg_i & ex_wd_i match -> ex_wdata_i;
//  mem_wreg_i & mem_wd_i match -> mem_wdata_i; else regfile data. Only when port is read-enabled.
//  Load-use: stallreq_o = id_valid_i & ex_valid_o & ex_is_load_o & ex_wd_o!=0 & (ex_wd_o matches an
//  enabled read addr). Exactly one bubble per load-use (after edge, load leaves ex_*, MEM forward covers).
//  Register update priority at each edge: rst > flush_i (bubble) > stall_i (hold all, incl. invalid flag=0)
//  > stallreq_o (bubble) > !id_valid_i (bubble) > load decoded entry. Latency: 1 cycle decode-to-ex_*.
//  Bubble = all ex_* zero, ex_valid_o=0. flush_i & stall_i same cycle: flush wins.
//  stallreq_o is masked while stall_i=1 (upstream already held). Width: operands truncated/extended to DATA_W.
// TESTING
//  ori $1,$0,0x1100 -> next cycle ex_reg1_o=0, ex_reg2_o=0x1100, ex_wd_o=1, aluop EXE_OR_OP, ex_wreg_o=1.
//  ex_wreg_i=1,ex_wd_i=3,ex_wdata_i=0xA5, mem same reg 0xFF; or $4,$3,$3 -> both operands 0xA5.
//  lw $2,4($1) then or $5,$2,$0 -> stallreq_o=1 one cycle, one bubble, then or issues with MEM forward.
//  stall_i=1 for 3 cycles holding andi entry -> ex_* unchanged; flush_i with stall_i -> ex_valid_o=0.
//  opcode 6'b111111 valid -> invalid_inst_o=1 one cycle, ex_wreg_o=0; rst mid-stream -> all ex_* 0 next edge.
//  Write to/read of $0 with ex forward of wd=0 -> operand stays 0, no stallreq on lw $0.

Source files
------------

// File: rtl/id_pipe.sv
// Decode stage with built-in ID/EX register: logic/LUI/LW decode, operand forwarding,
// load-use bubble insertion and downstream stall/flush handling.
module id_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc_i,
  input  logic [31:0]           inst_i,
  input  logic                  id_valid_i,
  input  logic [DATA_W-1:0]     reg1_data_i,
  input  logic [DATA_W-1:0]     reg2_data_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  stallreq_o,
  output logic                  ex_valid_o,
  output logic [ADDR_W-1:0]     ex_pc_o,
  output logic [7:0]            ex_aluop_o,
  output logic [2:0]            ex_alusel_o,
  output logic [DATA_W-1:0]     ex_reg1_o,
  output logic [DATA_W-1:0]     ex_reg2_o,
  output logic [REG_ADDR_W-1:0] ex_wd_o,
  output logic                  ex_wreg_o,
  output logic                  ex_is_load_o,
  output logic                  invalid_inst_o
);

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W-1:0]     pc;
    logic [7:0]            aluop;
    logic [2:0]            alusel;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic                  is_load;
  } entry_t;

  entry_t                dec_s;
  entry_t                ex_r;
  logic                  invalid_r;
  logic                  re1_s;
  logic                  re2_s;
  logic                  legal_s;
  logic                  stallreq_s;
  logic [DATA_W-1:0]     imm_s;
  logic [5:0]            op_s;
  logic [5:0]            funct_s;
  logic [REG_ADDR_W-1:0] rs_s;
  logic [REG_ADDR_W-1:0] rt_s;
  logic [REG_ADDR_W-1:0] rd_s;

  assign op_s    = inst_i[31:26];
  assign funct_s = inst_i[5:0];
  assign rs_s    = REG_ADDR_W'(inst_i[25:21]);
  assign rt_s    = REG_ADDR_W'(inst_i[20:16]);
  assign rd_s    = REG_ADDR_W'(inst_i[15:11]);

  // Operand select: $0 is hard zero, then EX result, then MEM result, then regfile.
  function automatic logic [DATA_W-1:0] fwd(
    input logic                  re,
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     rf_data,
    input logic [DATA_W-1:0]     unread,
    input logic                  exw,
    input logic [REG_ADDR_W-1:0] exd,
    input logic [DATA_W-1:0]     exdat,
    input logic                  mw,
    input logic [REG_ADDR_W-1:0] md,
    input logic [DATA_W-1:0]     mdat
  );
    logic [DATA_W-1:0] r;
    if (!re) begin
      r = unread;
    end else if (addr == '0) begin
      r = '0;
    end else if (exw && (exd == addr)) begin
      r = exdat;
    end else if (mw && (md == addr)) begin
      r = mdat;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

  // Instruction decode and operand resolution for the entry about to enter ID/EX.
  always_comb begin
    dec_s       = '0;
    re1_s       = 1'b0;
    re2_s       = 1'b0;
    legal_s     = 1'b0;
    imm_s       = '0;
    dec_s.valid = 1'b1;
    dec_s.pc    = pc_i;
    case (op_s)
      OP_SPECIAL: begin
        if (inst_i == 32'h0000_0000) begin
          legal_s = 1'b1;
        end else begin
          legal_s      = 1'b1;
          re1_s        = 1'b1;
          re2_s        = 1'b1;
          dec_s.wd     = rd_s;
          dec_s.wreg   = 1'b1;
          dec_s.alusel = EXE_RES_LOGIC;
          case (funct_s)
            FN_AND:  dec_s.aluop = EXE_AND_OP;
            FN_OR:   dec_s.aluop = EXE_OR_OP;
            FN_XOR:  dec_s.aluop = EXE_XOR_OP;
            FN_NOR:  dec_s.aluop = EXE_NOR_OP;
            default: begin
              legal_s = 1'b0;
              re1_s   = 1'b0;
              re2_s   = 1'b0;
            end
          endcase
        end
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        legal_s      = 1'b1;
        re1_s        = 1'b1;
        imm_s        = DATA_W'(inst_i[15:0]);
        dec_s.wd     = rt_s;
        dec_s.wreg   = 1'b1;
        dec_s.alusel = EXE_RES_LOGIC;
        dec_s.aluop  = (op_s == OP_ANDI) ? EXE_AND_OP :
                       (op_s == OP_ORI)  ? EXE_OR_OP  : EXE_XOR_OP;
      end
      OP_LUI: begin
        legal_s      = 1'b1;
        imm_s        = DATA_W'({inst_i[15:0], 16'h0000});
        dec_s.wd     = rt_s;
        dec_s.wreg   = 1'b1;
        dec_s.alusel = EXE_RES_LOGIC;
        dec_s.aluop  = EXE_OR_OP;
      end
      OP_LW: begin
        legal_s       = 1'b1;
        re1_s         = 1'b1;
        imm_s         = DATA_W'($signed(inst_i[15:0]));
        dec_s.wd      = rt_s;
        dec_s.wreg    = 1'b1;
        dec_s.is_load = 1'b1;
        dec_s.alusel  = EXE_RES_ARITHMETIC;
        dec_s.aluop   = EXE_ADD_OP;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
    dec_s.reg1 = fwd(re1_s, rs_s, reg1_data_i, '0, ex_wreg_i, ex_wd_i, ex_wdata_i,
                     mem_wreg_i, mem_wd_i, mem_wdata_i);
    dec_s.reg2 = fwd(re2_s, rt_s, reg2_data_i, imm_s, ex_wreg_i, ex_wd_i, ex_wdata_i,
                     mem_wreg_i, mem_wd_i, mem_wdata_i);
  end

  // A load in ID/EX cannot forward yet; one bubble lets the MEM path supply the value.
  assign stallreq_s = !stall_i && id_valid_i && ex_r.valid && ex_r.is_load &&
                      (ex_r.wd != '0) &&
                      ((re1_s && (rs_s == ex_r.wd)) || (re2_s && (rt_s == ex_r.wd)));

  // ID/EX register update: rst > flush > stall > load-use > no input > decoded entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r      <= '0;
      invalid_r <= 1'b0;
    end else if (flush_i) begin
      ex_r      <= '0;
      invalid_r <= 1'b0;
    end else if (stall_i) begin
      ex_r      <= ex_r;
      invalid_r <= 1'b0;
    end else if (stallreq_s || !id_valid_i) begin
      ex_r      <= '0;
      invalid_r <= 1'b0;
    end else if (!legal_s) begin
      ex_r      <= '0;
      invalid_r <= 1'b1;
    end else begin
      ex_r      <= dec_s;
      invalid_r <= 1'b0;
    end
  end

  assign reg1_read_o    = re1_s;
  assign reg2_read_o    = re2_s;
  assign reg1_addr_o    = rs_s;
  assign reg2_addr_o    = rt_s;
  assign stallreq_o     = stallreq_s;
  assign ex_valid_o     = ex_r.valid;
  assign ex_pc_o        = ex_r.pc;
  assign ex_aluop_o     = ex_r.aluop;
  assign ex_alusel_o    = ex_r.alusel;
  assign ex_reg1_o      = ex_r.reg1;
  assign ex_reg2_o      = ex_r.reg2;
  assign ex_wd_o        = ex_r.wd;
  assign ex_wreg_o      = ex_r.wreg;
  assign ex_is_load_o   = ex_r.is_load;
  assign invalid_inst_o = invalid_r;

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: directed instructions push expected ID/EX entries,
// a negedge monitor pops and compares whenever the DUT presents a valid entry.
module tb_id_pipe;

  localparam logic [7:0] NOP_OP = 8'b0000_0000;
  localparam logic [7:0] AND_OP = 8'b0010_0100;
  localparam logic [7:0] OR_OP  = 8'b0010_0101;
  localparam logic [7:0] XOR_OP = 8'b0010_0110;
  localparam logic [7:0] NOR_OP = 8'b0010_0111;
  localparam logic [7:0] ADD_OP = 8'b0010_0000;
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_ARITH = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i;
  logic        id_valid_i;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        ex_wreg_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        stall_i, flush_i, stallreq_o;
  logic        ex_valid_o, ex_wreg_o, ex_is_load_o, invalid_inst_o;
  logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [4:0]  ex_wd_o;

  always #5 clk = ~clk;

  // Regfile stand-in: every register, $0 included, reads a nonzero tagged value.
  assign reg1_data_i = 32'hDEAD_0000 | {27'd0, reg1_addr_o};
  assign reg2_data_i = 32'hDEAD_0000 | {27'd0, reg2_addr_o};

  id_pipe dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .id_valid_i(id_valid_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stall_i(stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o),
    .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_is_load_o(ex_is_load_o),
    .invalid_inst_o(invalid_inst_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic        ld;
  } exp_t;

  exp_t        q[$];
  exp_t        none;
  exp_t        held;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [7:0] op, input logic [2:0] sel,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                              input logic wreg, input logic ld);
    exp_t e;
    e.pc = p; e.op = op; e.sel = sel; e.r1 = r1; e.r2 = r2; e.wd = wd; e.wreg = wreg; e.ld = ld;
    return e;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  // Monitor: valid entries are popped and compared, bubbles must be all-zero.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ex_valid_o === 1'b1) begin
      if (q.size() == 0) begin
        chk("queue_nonempty_on_entry", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("ex_pc", ex_pc_o, e.pc);
        chk("ex_aluop", 32'(ex_aluop_o), 32'(e.op));
        chk("ex_alusel", 32'(ex_alusel_o), 32'(e.sel));
        chk("ex_reg1", ex_reg1_o, e.r1);
        chk("ex_reg2", ex_reg2_o, e.r2);
        chk("ex_wd", 32'(ex_wd_o), 32'(e.wd));
        chk("ex_wreg", 32'(ex_wreg_o), 32'(e.wreg));
        chk("ex_is_load", 32'(ex_is_load_o), 32'(e.ld));
      end
    end else begin
      chk("bubble_zero", 32'(|{ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o,
                               ex_reg2_o, ex_wd_o, ex_wreg_o, ex_is_load_o}), 32'd0);
    end
  end

  task automatic cyc(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                     input logic sr_exp, input logic do_push, input exp_t e);
    inst_i = ins; id_valid_i = v; stall_i = st; flush_i = fl; pc_i = pc;
    if (do_push) q.push_back(e);
    #2;
    chk("stallreq", 32'(stallreq_o), 32'(sr_exp));
    @(posedge clk);
    #1;
    pc = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0000_0100; pc_i = pc;
    inst_i = enc_i(6'b001101, 5'd0, 5'd1, 16'h1100); id_valid_i = 1'b1;
    ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'd0;
    mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'd0;
    stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(ex_valid_o), 32'd0);
    chk("reset_invalid", 32'(invalid_inst_o), 32'd0);
    rst = 1'b0;

    // ori $1,$0,0x1100
    cyc(enc_i(6'b001101, 5'd0, 5'd1, 16'h1100), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, OR_OP, RES_LOGIC, 32'h0, 32'h1100, 5'd1, 1'b1, 1'b0));
    // or $4,$3,$3 with EX and MEM both writing $3: EX wins
    ex_wreg_i = 1'b1; ex_wd_i = 5'd3; ex_wdata_i = 32'hA5;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'hFF;
    cyc(enc_r(5'd3, 5'd3, 5'd4, 6'b100101), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, OR_OP, RES_LOGIC, 32'hA5, 32'hA5, 5'd4, 1'b1, 1'b0));
    // and $6,$7,$8 with MEM forward on $8 only
    ex_wd_i = 5'd9; mem_wd_i = 5'd8; mem_wdata_i = 32'h1234;
    cyc(enc_r(5'd7, 5'd8, 5'd6, 6'b100100), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, AND_OP, RES_LOGIC, 32'hDEAD_0007, 32'h1234, 5'd6, 1'b1, 1'b0));
    ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
    // lui $9,0xABCD (rs field nonzero but not read)
    cyc(enc_i(6'b001111, 5'd5, 5'd9, 16'hABCD), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, OR_OP, RES_LOGIC, 32'h0, 32'hABCD_0000, 5'd9, 1'b1, 1'b0));
    // xori $10,$11,0x8001 (zero-extended)
    cyc(enc_i(6'b001110, 5'd11, 5'd10, 16'h8001), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, XOR_OP, RES_LOGIC, 32'hDEAD_000B, 32'h0000_8001, 5'd10, 1'b1, 1'b0));
    // nor $12,$13,$14
    cyc(enc_r(5'd13, 5'd14, 5'd12, 6'b100111), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, NOR_OP, RES_LOGIC, 32'hDEAD_000D, 32'hDEAD_000E, 5'd12, 1'b1, 1'b0));
    // lw $2,-4($1) (sign-extended)
    cyc(enc_i(6'b100011, 5'd1, 5'd2, 16'hFFFC), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, ADD_OP, RES_ARITH, 32'hDEAD_0001, 32'hFFFF_FFFC, 5'd2, 1'b1, 1'b1));
    // or $5,$2,$0: load-use stall, one bubble, then MEM forward
    cyc(enc_r(5'd2, 5'd0, 5'd5, 6'b100101), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, none);
    mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 32'h77;
    cyc(enc_r(5'd2, 5'd0, 5'd5, 6'b100101), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, OR_OP, RES_LOGIC, 32'h77, 32'h0, 5'd5, 1'b1, 1'b0));
    mem_wreg_i = 1'b0;
    // andi $15,$16,0xF0 then three stall cycles holding it
    held = mk(pc, AND_OP, RES_LOGIC, 32'hDEAD_0010, 32'hF0, 5'd15, 1'b1, 1'b0);
    cyc(enc_i(6'b001100, 5'd16, 5'd15, 16'h00F0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, held);
    for (int i = 0; i < 3; i++)
      cyc(enc_i(6'b001101, 5'd1, 5'd17, 16'h0005), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, held);
    // flush together with stall
    cyc(enc_i(6'b001110, 5'd1, 5'd3, 16'h0001), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, none);
    chk("flush_over_stall", 32'(ex_valid_o), 32'd0);
    // undecodable opcode and funct
    cyc(enc_i(6'b111111, 5'd1, 5'd2, 16'h0003), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, none);
    chk("invalid_opcode_pulse", 32'(invalid_inst_o), 32'd1);
    chk("invalid_wreg", 32'(ex_wreg_o), 32'd0);
    cyc(enc_r(5'd1, 5'd2, 5'd3, 6'b000001), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, none);
    chk("invalid_funct_pulse", 32'(invalid_inst_o), 32'd1);
    cyc(enc_i(6'b001101, 5'd0, 5'd18, 16'h0007), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, OR_OP, RES_LOGIC, 32'h0, 32'h7, 5'd18, 1'b1, 1'b0));
    chk("invalid_cleared", 32'(invalid_inst_o), 32'd0);
    // lw $0,8($1) then or $7,$0,$0 with EX forwarding wd=0
    cyc(enc_i(6'b100011, 5'd1, 5'd0, 16'h0008), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, ADD_OP, RES_ARITH, 32'hDEAD_0001, 32'h8, 5'd0, 1'b1, 1'b1));
    ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'h55;
    cyc(enc_r(5'd0, 5'd0, 5'd7, 6'b100101), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, OR_OP, RES_LOGIC, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0));
    ex_wreg_i = 1'b0;
    // lw $20 then dependent or under stall: stallreq masked, lw held
    held = mk(pc, ADD_OP, RES_ARITH, 32'hDEAD_0001, 32'h0, 5'd20, 1'b1, 1'b1);
    cyc(enc_i(6'b100011, 5'd1, 5'd20, 16'h0000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, held);
    cyc(enc_r(5'd20, 5'd20, 5'd21, 6'b100101), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, held);
    cyc(enc_r(5'd20, 5'd20, 5'd21, 6'b100101), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, none);
    // all-zero instruction is a valid NOP
    cyc(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
    // reset mid-stream
    cyc(enc_i(6'b001101, 5'd0, 5'd1, 16'h0001), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        mk(pc, OR_OP, RES_LOGIC, 32'h0, 32'h1, 5'd1, 1'b1, 1'b0));
    rst = 1'b1;
    cyc(enc_i(6'b001101, 5'd0, 5'd2, 16'h0002), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, none);
    chk("reset_mid_valid", 32'(ex_valid_o), 32'd0);
    rst = 1'b0;
    repeat (2) cyc(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, none);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
